// File: rtl/fft8_ctrl_if.sv
// Frame handshake bundle between the FFT sequencing controller and its neighbours.
// The slave modport is the controller's view; the master modport is the view of the surrounding logic.
interface fft8_ctrl_if;
   logic in_valid;
   logic in_ready;
   logic out_valid;
   logic out_ready;

   modport slave (
      input  in_valid,
      output in_ready,
      output out_valid,
      input  out_ready
   );

   modport master (
      output in_valid,
      input  in_ready,
      input  out_valid,
      output out_ready
   );
endinterface

// File: rtl/fft8_ctrl.sv
// Stage-enable sequencer and completed-frame counter for the 8-point, 3-stage FFT core.
// Define FFT8_CTRL_PIPE_EN to get the pipelined valid-bit scheme; otherwise the sequential FSM is built.
module fft8_ctrl #(
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             clear,
   fft8_ctrl_if.slave       bus,
   output logic             en_bf1_1,
   output logic             en_bf1_2,
   output logic             en_bf1_3,
   output logic             en_bf1_4,
   output logic             en_bf2_1,
   output logic             en_bf2_2,
   output logic             en_bf3,
   output logic             busy,
   output logic [CNT_W-1:0] frame_cnt
);

   logic in_rdy;
   logic accept;
   logic en2;
   logic en3;
   logic out_vld;
   logic handshake;

   assign accept = bus.in_valid & in_rdy;

`ifdef FFT8_CTRL_PIPE_EN
   logic v1;
   logic v2;
   logic v3;
   logic stall;

   // Stages hold their operands while the output is blocked, so the whole pipe freezes.
   assign stall  = v3 & ~bus.out_ready;

   always_comb begin
      in_rdy  = ~stall & ~clear;
      en2     = v1 & ~stall & ~clear;
      en3     = v2 & ~stall & ~clear;
      out_vld = v3;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         v1 <= 1'b0;
         v2 <= 1'b0;
         v3 <= 1'b0;
      end else if (clear) begin
         v1 <= 1'b0;
         v2 <= 1'b0;
         v3 <= 1'b0;
      end else if (!stall) begin
         v1 <= accept;
         v2 <= v1;
         v3 <= v2;
      end
   end

   assign busy = v1 | v2 | v3;
`else
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ST2  = 2'd1,
      ST3  = 2'd2,
      OUT  = 2'd3
   } state_t;

   state_t state;
   state_t state_nxt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      in_rdy    = 1'b0;
      en2       = 1'b0;
      en3       = 1'b0;
      out_vld   = 1'b0;
      case (state)
         IDLE: begin
            in_rdy = ~clear;
            if (bus.in_valid && in_rdy) state_nxt = ST2;
         end
         ST2: begin
            en2       = ~clear;
            state_nxt = ST3;
         end
         ST3: begin
            en3       = ~clear;
            state_nxt = OUT;
         end
         OUT: begin
            out_vld = 1'b1;
            // A consumed result frees the core, so a new frame may enter in the same cycle.
            if (bus.out_ready) begin
               in_rdy    = ~clear;
               state_nxt = (bus.in_valid && in_rdy) ? ST2 : IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
      if (clear) state_nxt = IDLE;
   end

   assign busy = (state != IDLE);
`endif

   assign handshake = out_vld & bus.out_ready & ~clear;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)       frame_cnt <= '0;
      else if (handshake) frame_cnt <= frame_cnt + 1'b1;
   end

   assign bus.in_ready  = in_rdy;
   assign bus.out_valid = out_vld;

   assign en_bf1_1 = accept;
   assign en_bf1_2 = accept;
   assign en_bf1_3 = accept;
   assign en_bf1_4 = accept;
   assign en_bf2_1 = en2;
   assign en_bf2_2 = en2;
   assign en_bf3   = en3;

endmodule

// File: tb/tb_fft8_ctrl.sv
// Directed self-checking bench for fft8_ctrl; expectations cover both the default and FFT8_CTRL_PIPE_EN builds.
module tb_fft8_ctrl;

`ifdef FFT8_CTRL_PIPE_EN
   localparam bit PIPE = 1'b1;
`else
   localparam bit PIPE = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic clear = 1'b0;

   always #5 clk = ~clk;

   fft8_ctrl_if bus ();
   fft8_ctrl_if bus2 ();

   logic e11, e12, e13, e14, e21, e22, e3, busy;
   logic [7:0] cnt;
   logic d11, d12, d13, d14, d21, d22, d3, dbusy;
   logic [1:0] cnt2;

   assign bus2.in_valid  = bus.in_valid;
   assign bus2.out_ready = bus.out_ready;

   fft8_ctrl #(.CNT_W(8)) dut (
      .clk(clk), .reset_n(reset_n), .clear(clear), .bus(bus),
      .en_bf1_1(e11), .en_bf1_2(e12), .en_bf1_3(e13), .en_bf1_4(e14),
      .en_bf2_1(e21), .en_bf2_2(e22), .en_bf3(e3),
      .busy(busy), .frame_cnt(cnt)
   );

   fft8_ctrl #(.CNT_W(2)) dut2 (
      .clk(clk), .reset_n(reset_n), .clear(clear), .bus(bus2),
      .en_bf1_1(d11), .en_bf1_2(d12), .en_bf1_3(d13), .en_bf1_4(d14),
      .en_bf2_1(d21), .en_bf2_2(d22), .en_bf3(d3),
      .busy(dbusy), .frame_cnt(cnt2)
   );

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // exp packs {in_ready, en_bf1, en_bf2, en_bf3, out_valid, busy}
   task automatic check_st(input string tag, input logic [5:0] exp);
      check(tag, {bus.in_ready, e11, e12, e13, e14, e21, e22, e3, bus.out_valid, busy},
            {exp[5], {4{exp[4]}}, {2{exp[3]}}, exp[2], exp[1], exp[0]});
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      clear         = 1'b0;
      reset_n       = 1'b0;
      step();
      step();
      reset_n = 1'b1;
   endtask

   logic [5:0] stall_tab [10];
   logic [1:0] wrap_tab [5];
   int acc;
   int period;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      // Reset state and single-frame latency
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      reset_n       = 1'b0;
      step();
      check_st("rst_status", 6'b100000);
      check("rst_cnt", cnt, 8'd0);
      reset_n = 1'b1;
      bus.in_valid = 1'b1;
      #1;
      check_st("lat_c0", 6'b110000);
      step();
      bus.in_valid = 1'b0;
      #1;
      check_st("lat_c1", PIPE ? 6'b101001 : 6'b001001);
      step();
      check_st("lat_c2", PIPE ? 6'b100101 : 6'b000101);
      step();
      check_st("lat_c3", 6'b100011);
      check("lat_cnt3", cnt, 8'd0);
      step();
      check_st("lat_c4", 6'b100000);
      check("lat_cnt4", cnt, 8'd1);

      // Throughput with in_valid held for 9 cycles
      do_reset();
      for (int c = 0; c < 13; c++) begin
         bus.in_valid = (c < 9);
         #1;
         check($sformatf("thr_acc_c%0d", c), e11,
               PIPE ? (c < 9) : (c < 9 && (c % 3) == 0));
         check($sformatf("thr_ov_c%0d", c), bus.out_valid,
               PIPE ? (c >= 3 && c <= 11) : (c == 3 || c == 6 || c == 9));
         step();
      end
      check("thr_cnt", cnt, PIPE ? 8'd9 : 8'd3);

      // Output stall with out_ready low in cycles 3-5
      if (PIPE)
         stall_tab = '{6'b110000, 6'b111001, 6'b111101, 6'b000011, 6'b000011,
                       6'b000011, 6'b101111, 6'b100111, 6'b100011, 6'b100000};
      else
         stall_tab = '{6'b110000, 6'b001001, 6'b000101, 6'b000011, 6'b000011,
                       6'b000011, 6'b100011, 6'b100000, 6'b100000, 6'b100000};
      do_reset();
      for (int c = 0; c < 10; c++) begin
         bus.in_valid  = PIPE ? (c < 3) : (c == 0);
         bus.out_ready = !(c >= 3 && c <= 5);
         #1;
         check_st($sformatf("stall_c%0d", c), stall_tab[c]);
         step();
      end
      check("stall_cnt", cnt, PIPE ? 8'd3 : 8'd1);

      // Clear in the en_bf3 cycle
      do_reset();
      bus.in_valid = 1'b1;
      step();
      bus.in_valid = 1'b0;
      step();
      clear = 1'b1;
      #1;
      check_st("clr_c2", 6'b000001);
      step();
      clear = 1'b0;
      for (int c = 3; c < 6; c++) begin
         #1;
         check_st($sformatf("clr_c%0d", c), 6'b100000);
         step();
      end
      check("clr_cnt", cnt, 8'd0);

      // Counter wrap on a 2-bit instance
      wrap_tab = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
      period   = PIPE ? 1 : 3;
      acc      = 0;
      do_reset();
      for (int c = 0; c < 19; c++) begin
         bus.in_valid = (acc < 5);
         #1;
         if (e11) acc++;
         for (int i = 0; i < 5; i++)
            if (c == 4 + period * i)
               check($sformatf("wrap_f%0d", i + 1), cnt2, wrap_tab[i]);
         step();
      end
      check("wrap_cnt8", cnt, 8'd5);

      // Asynchronous reset in ST3 / with v2 set
      do_reset();
      bus.in_valid = 1'b1;
      step();
      bus.in_valid = 1'b0;
      step();
      check_st("arst_pre", PIPE ? 6'b100101 : 6'b000101);
      #2;
      reset_n = 1'b0;
      #1;
      check_st("arst_now", 6'b100000);
      check("arst_cnt", cnt, 8'd0);
      step();
      reset_n = 1'b1;
      for (int c = 0; c < 5; c++) begin
         #1;
         check($sformatf("arst_ov_c%0d", c), {bus.out_valid, busy}, 2'b00);
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
